// File: rtl/lfsr_stimulus_gen.sv
// Multi-channel Fibonacci LFSR stimulus source with valid/ready output,
// runtime reseed, bounded run length and all-zero lockup protection.
module lfsr_stimulus_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter int unsigned STEPS       = 3,
  parameter logic [CHANNELS*WIDTH-1:0] SEEDS = 32'hAB6A5A55,
  parameter int unsigned NUM_SAMPLES = 16,
  localparam int unsigned DW = CHANNELS * WIDTH,
  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          seed_load,
  input  logic [DW-1:0] seed_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] sample_cnt,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        fsm;
  logic [DW-1:0] adv_data;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [DW-1:0] advance(input logic [DW-1:0] w);
    logic [DW-1:0]    r;
    logic [WIDTH-1:0] c;
    r = w;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      c = r[ch*WIDTH +: WIDTH];
      for (int unsigned s = 0; s < STEPS; s++) begin
        c = shift_once(c);
      end
      r[ch*WIDTH +: WIDTH] = c;
    end
    return r;
  endfunction

  // An all-zero channel would never leave zero, so it is seeded with 1.
  function automatic logic [DW-1:0] zero_fix(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (w[ch*WIDTH +: WIDTH] == '0) begin
        r[ch*WIDTH +: WIDTH] = WIDTH'(1);
      end
    end
    return r;
  endfunction

  always_comb begin
    adv_data = '0;
    adv_data = advance(out_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= IDLE;
      out_data   <= zero_fix(SEEDS);
      out_valid  <= 1'b0;
      sample_cnt <= '0;
      done       <= 1'b0;
    end else if (seed_load) begin
      fsm        <= IDLE;
      out_data   <= zero_fix(seed_in);
      out_valid  <= 1'b0;
      sample_cnt <= '0;
      done       <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            fsm       <= RUN;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (out_ready) begin
            out_data   <= adv_data;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CW'(NUM_SAMPLES - 1)) begin
              fsm       <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            fsm        <= RUN;
            out_valid  <= 1'b1;
            sample_cnt <= '0;
            done       <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
